id_ex_pipe_reg: RTL



---
 rtl/id_ex_pipe_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register: one-cycle capture, bubble on flush, hold on freeze.
// DIV/MOD stay in EX for MC_LAT cycles while stall_out (state-only) holds decode and fetch.
module id_ex_pipe_reg #(
    parameter int               DATA_W  = 32,
    parameter int               REG_W   = 4,
    parameter int               CMD_W   = 4,
    parameter logic [CMD_W-1:0] CMD_DIV = 4'd3,
    parameter logic [CMD_W-1:0] CMD_MOD = 4'd4,
    parameter int               MC_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              is_imm_in,
    input  logic              is_str_in,
    input  logic              is_ldr_in,
    input  logic              is_cmp_in,
    input  logic              branch_en_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic [CMD_W-1:0]  branch_cmd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val1_in,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [REG_W-1:0]  src1_in,
    input  logic [REG_W-1:0]  src2_in,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              is_imm_out,
    output logic              is_str_out,
    output logic              is_ldr_out,
    output logic              is_cmp_out,
    output logic              branch_en_out,
    output logic [CMD_W-1:0]  exe_cmd_out,
    output logic [CMD_W-1:0]  branch_cmd_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val1_out,
    output logic [DATA_W-1:0] val2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [REG_W-1:0]  src1_out,
    output logic [REG_W-1:0]  src2_out,
    output logic              valid_out,
    output logic              stall_out
);

    localparam int         PAY_W    = 8 + 2*CMD_W + 4*DATA_W + 3*REG_W;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic       MC_EN    = (MC_LAT > 1);
    localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 1);

    logic [PAY_W-1:0] w_pay_in;
    logic [PAY_W-1:0] r_pay;
    logic             r_valid;
    logic [0:0]       r_state;
    logic [3:0]       r_cnt;
    logic             w_is_mc;

    assign w_pay_in = {wb_en_in, mem_r_en_in, mem_w_en_in, is_imm_in,
                       is_str_in, is_ldr_in, is_cmp_in, branch_en_in,
                       exe_cmd_in, branch_cmd_in,
                       pc_in, val1_in, val2_in, imm_in,
                       dest_in, src1_in, src2_in};

    assign {wb_en_out, mem_r_en_out, mem_w_en_out, is_imm_out,
            is_str_out, is_ldr_out, is_cmp_out, branch_en_out,
            exe_cmd_out, branch_cmd_out,
            pc_out, val1_out, val2_out, imm_out,
            dest_out, src1_out, src2_out} = r_pay;

    assign w_is_mc   = MC_EN && ((exe_cmd_in == CMD_DIV) || (exe_cmd_in == CMD_MOD));
    assign valid_out = r_valid;
    assign stall_out = (r_state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pay   <= '0;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else if (r_state == ST_BUSY) begin
            // Payload is frozen in BUSY; only the countdown moves, and only when memory is not stalling.
            if (!freeze) begin
                if (r_cnt <= 4'd1) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end else if (!freeze) begin
            if (flush) begin
                r_pay   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_pay   <= w_pay_in;
                r_valid <= 1'b1;
                if (w_is_mc) begin
                    r_state <= ST_BUSY;
                    r_cnt   <= CNT_INIT;
                end
            end
        end
    end

endmodule
